// File: rtl/hex8_scan.sv
// hex8_scan: eight-digit seven-segment scan controller feeding a 74HC595 serialiser.
// Holds a 32-bit hex value, presents one digit per scan slot as a 16-bit
// {segments, digit-select} word, and pulses a one-cycle strobe with each new word.
//
// Parameters:
//   SCAN_MAX       clocks per digit slot (>= 2; >= 132 when driving the 595 serialiser)
//   SEG_ACTIVE_LOW 1: segment lit when its bit is 0 (common anode)
//   SEL_ACTIVE_LOW 1: digit selected when its bit is 0
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   Disp_Data  in   nibble i is the hex value of digit i (digit 0 rightmost)
//   Dot        in   bit i lights the decimal point of digit i
//   Blank      in   bit i turns off every segment of digit i (still selected)
//   Data_out   out  [15:8] segments {dp,g,f,e,d,c,b,a}, [7:0] one-hot digit select
//   Data_vld   out  one-cycle pulse when Data_out takes a new word
module hex8_scan #(
  parameter int unsigned SCAN_MAX       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Disp_Data,
  input  logic [7:0]  Dot,
  input  logic [7:0]  Blank,
  output logic [15:0] Data_out,
  output logic        Data_vld
);

  localparam int unsigned CntW    = (SCAN_MAX > 1) ? $clog2(SCAN_MAX) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_MAX - 1);
  localparam logic [7:0] SegOff  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] SelOff  = SEL_ACTIVE_LOW ? 8'hFF : 8'h00;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [31:0]     shadow_data_q;
  logic [7:0]      shadow_dot_q;
  logic [7:0]      shadow_blank_q;

  logic        tick;
  logic        frame_start;
  logic [31:0] cur_data;
  logic [7:0]  cur_dot;
  logic [7:0]  cur_blank;
  logic [3:0]  nib;
  logic [7:0]  seg_raw;
  logic [15:0] word;

  always_comb begin
    tick        = (cnt_q == CntLast);
    frame_start = tick && (idx_q == 3'd0);
    // Digit 0 of a frame uses the live inputs so it agrees with what the
    // shadows capture on the same edge; later digits use the frozen copy.
    cur_data    = frame_start ? Disp_Data : shadow_data_q;
    cur_dot     = frame_start ? Dot       : shadow_dot_q;
    cur_blank   = frame_start ? Blank     : shadow_blank_q;
    nib         = cur_data[{idx_q, 2'b00} +: 4];
    seg_raw     = cur_blank[idx_q] ? 8'h00 : {cur_dot[idx_q], decode(nib)};
    word        = {seg_raw ^ SegOff, (8'b1 << idx_q) ^ SelOff};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q          <= '0;
      idx_q          <= 3'd0;
      shadow_data_q  <= 32'h0;
      shadow_dot_q   <= 8'h00;
      shadow_blank_q <= 8'h00;
      Data_out       <= {SegOff, SelOff};
      Data_vld       <= 1'b0;
    end else begin
      cnt_q    <= tick ? '0 : cnt_q + CntW'(1);
      Data_vld <= tick;
      if (tick) begin
        idx_q    <= idx_q + 3'd1;
        Data_out <= word;
      end
      if (frame_start) begin
        shadow_data_q  <= Disp_Data;
        shadow_dot_q   <= Dot;
        shadow_blank_q <= Blank;
      end
    end
  end

endmodule

// File: tb/tb_hex8_scan.sv
// Bench for hex8_scan: two instances (default polarity and inverted polarity) share
// stimulus; a reference model pushes expected words into a queue and a monitor checks them.
module tb_hex8_scan;

  localparam int unsigned SCAN = 8;
  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] Disp_Data;
  logic [7:0]  Dot;
  logic [7:0]  Blank;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic        vld_a;
  logic        vld_b;

  always #5 Clk = ~Clk;

  hex8_scan #(.SCAN_MAX(SCAN)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .Disp_Data(Disp_Data), .Dot(Dot), .Blank(Blank),
    .Data_out(out_a), .Data_vld(vld_a)
  );

  hex8_scan #(.SCAN_MAX(SCAN), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b1)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Disp_Data(Disp_Data), .Dot(Dot), .Blank(Blank),
    .Data_out(out_b), .Data_vld(vld_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word a display should show for digit d given a frame's data.
  function automatic logic [15:0] ref_word(input int unsigned d, input logic [31:0] data,
                                           input logic [7:0] dot, input logic [7:0] blank,
                                           input bit seg_low, input bit sel_low);
    logic [3:0] v;
    logic [7:0] seg;
    logic [7:0] sel;
    v   = data[4*d +: 4];
    seg = blank[d] ? 8'h00 : {dot[d], SEG_TBL[v]};
    if (seg_low) seg = ~seg;
    sel = 8'b1 << d;
    if (sel_low) sel = ~sel;
    return {seg, sel};
  endfunction

  typedef struct {
    int unsigned cyc;
    int unsigned digit;
    logic [15:0] wa;
    logic [15:0] wb;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n = 0;          // edges since reset release
  int unsigned pulse_digit = 0;
  logic [31:0] s_data  = 32'h0;
  logic [7:0]  s_dot   = 8'h00;
  logic [7:0]  s_blank = 8'h00;

  // Reference model: every SCAN-th edge after release emits the next digit, digits
  // cycling 0..7; the frame's data is whatever was on the inputs at the digit-0 edge.
  initial forever begin
    @(posedge Clk or negedge Reset_n);
    if (!Reset_n) begin
      n = 0;
      q.delete();
      s_data  = 32'h0;
      s_dot   = 8'h00;
      s_blank = 8'h00;
    end else begin
      cyc++;
      n++;
      if (n % SCAN == 0) begin
        int unsigned d;
        d = (n / SCAN - 1) % 8;
        if (d == 0) begin
          s_data  = Disp_Data;
          s_dot   = Dot;
          s_blank = Blank;
        end
        q.push_back('{cyc, d, ref_word(d, s_data, s_dot, s_blank, 1'b1, 1'b0),
                      ref_word(d, s_data, s_dot, s_blank, 1'b0, 1'b1)});
        pulse_digit = d;
      end
    end
  end

  // Monitor: pops an expectation on each strobe, otherwise checks the word is held.
  logic [15:0] last_a = 16'hFF00;
  logic [15:0] last_b = 16'h00FF;
  initial forever begin
    @(negedge Clk);
    if (!Reset_n) begin
      last_a = 16'hFF00;
      last_b = 16'h00FF;
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_pulse: digit %0d due at cycle %0d, now %0d", q[0].digit, q[0].cyc,
                 cyc);
        void'(q.pop_front());
      end
      if (vld_a) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
          exp_t e;
          e = q.pop_front();
          check($sformatf("word_d%0d", e.digit), out_a, e.wa);
          check($sformatf("word_pol_d%0d", e.digit), out_b, e.wb);
          check("vld_pol", 16'(vld_b), 16'h1);
          last_a = e.wa;
          last_b = e.wb;
        end else begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got vld=1 word %h expected vld=0 at cycle %0d", out_a,
                   cyc);
        end
      end else begin
        check("hold", out_a, last_a);
        check("hold_pol", out_b, last_b);
        check("vld_pol_idle", 16'(vld_b), 16'h0);
      end
    end
  end

  task automatic wait_digit(input int unsigned d);
    for (int k = 0; k < int'(SCAN) * 8 * 2 + 4; k++) begin
      @(negedge Clk);
      if (vld_a && pulse_digit == d) return;
    end
    total++;
    bad++;
    $display("FAIL wait_digit: no pulse for digit %0d, expected one within budget", d);
  endtask

  task automatic check_reset_state();
    check("rst_out", out_a, 16'hFF00);
    check("rst_vld", 16'(vld_a), 16'h0);
    check("rst_out_pol", out_b, 16'h00FF);
    check("rst_vld_pol", 16'(vld_b), 16'h0);
  endtask

  initial begin
    Reset_n   = 1'b0;
    Disp_Data = 32'h0;
    Dot       = 8'h00;
    Blank     = 8'h00;
    repeat (3) @(negedge Clk);
    check_reset_state();
    Reset_n = 1'b1;

    // First word after release: digit 0 showing "0".
    wait_digit(0);
    Disp_Data = 32'h89ABCDEF;
    wait_digit(0);
    wait_digit(0);

    // Decimal point on digit 0, digit 1 blanked.
    Dot       = 8'h01;
    Blank     = 8'h02;
    Disp_Data = 32'h00000012;
    wait_digit(0);
    wait_digit(1);
    wait_digit(0);

    // Mid-frame change must not tear the frame in progress.
    Dot       = 8'h00;
    Blank     = 8'h00;
    Disp_Data = 32'h0;
    wait_digit(0);
    wait_digit(3);
    Disp_Data = 32'hFFFFFFFF;
    wait_digit(0);
    wait_digit(7);

    // Asynchronous reset mid-slot, mid-frame.
    wait_digit(5);
    repeat (3) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 check_reset_state();
    repeat (2) @(negedge Clk);
    check_reset_state();
    Reset_n = 1'b1;
    wait_digit(0);

    // Randomised inputs changing at arbitrary points, including frame-start edges.
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(1, 20)) @(negedge Clk);
      Disp_Data = $urandom;
      Dot       = 8'($urandom);
      Blank     = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
    end
    wait_digit(0);
    wait_digit(0);
    repeat (3) @(negedge Clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: %0d words pending, expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hex8_scan.md
# hex8_scan

Eight-digit seven-segment scan controller that sits directly upstream of the 74HC595 serialiser in the display path. It holds a 32-bit hex display value, time-multiplexes it one digit at a time, decodes each nibble to a segment pattern, and presents a 16-bit `{segment, digit-select}` word with a one-cycle strobe. The strobe drives the serialiser's `EN` input, and the word drives its `Data_in`. One word is produced per scan slot, giving a full 8-digit frame every `8*SCAN_MAX` clocks.

## Interface
- `SCAN_MAX`, default 50000: clocks per digit slot (1 ms at 50 MHz). Legal minimum is 2. It must be ≥ 132 when driving the 595 serialiser, which needs 132 clocks per 16-bit transfer.
- `SEG_ACTIVE_LOW`, default 1: 1 means a segment is lit when its bit is 0 (common anode).
- `SEL_ACTIVE_LOW`, default 0: 1 means a digit is selected when its bit is 0.

Ports:
- `Clk` in 1: system clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Disp_Data` in 32: nibble i (`[4i+3:4i]`) is the hex value for digit i; digit 0 is the rightmost.
- `Dot` in 8: bit i lights the decimal point of digit i.
- `Blank` in 8: bit i forces all segments of digit i off, including DP. The digit is still selected.
- `Data_out` out 16: bits [15:8] are segments `{dp,g,f,e,d,c,b,a}`; bits [7:0] are the one-hot digit select.
- `Data_vld` out 1: one-cycle pulse when `Data_out` changes. Connects to the serialiser's `EN`.

## Operation
- Decode table, active-high, `{dp..a}` with dp=0:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
- DP bit [7] is set from `Dot[i]`. If `Blank[i]` is set, all 8 segment bits are cleared.
- If `SEG_ACTIVE_LOW` is set, the final 8 segment bits are inverted.
- Digit select is one-hot: bit i is set for digit i, and bit i alone. If `SEL_ACTIVE_LOW` is set, the 8 select bits are inverted.
- Slot counter `cnt` runs 0..`SCAN_MAX-1` and wraps. "Tick" means a cycle where `cnt == SCAN_MAX-1`.
- Index `idx` (3 bits) names the next digit to present. It resets to 0 and increments by 1 on every tick, wrapping 7→0.
- On a tick with `idx == 0` (frame start):
  - `Disp_Data`, `Dot` and `Blank` are captured into shadow registers.
  - Digit 0's word is computed from the live inputs on that same edge.
- On ticks with `idx` = 1..7, the word is computed from the shadow registers. Input changes mid-frame therefore never tear a frame.
- Shadow registers reset to 0. Between ticks, `Data_out` holds its value.

## Timing
- Reset values:
  - `cnt`=0, `idx`=0, shadows=0, `Data_vld`=0.
  - `Data_out` = all off: segments are `8'hFF` if `SEG_ACTIVE_LOW`, else `8'h00`; select is `8'hFF` if `SEL_ACTIVE_LOW`, else `8'h00`. With default parameters this is 16'hFF00.
- Output update:
  - On the tick edge, `Data_out` is registered with the new word and `Data_vld` is registered to 1.
  - Both are visible in the cycle after the tick.
  - `Data_vld` returns to 0 on the next edge, so it is exactly one cycle wide. It pulses once per `SCAN_MAX` clocks.
- First pulse after reset release comes `SCAN_MAX` edges later and carries digit 0.
- Word latency from input to output:
  - Digit 0: 1 clock after the frame-start tick.
  - Digits 1..7: use values frozen at frame start.
- Reset asserted mid-slot or mid-frame: all state returns to reset values immediately. The next pulse after release is again digit 0 at `SCAN_MAX` edges.
- Input changing on the exact frame-start tick edge: the value sampled at that edge is used for the whole frame.
- There is no back-pressure. The serialiser must finish within `SCAN_MAX` clocks, otherwise words are overwritten.

## Test plan
- **Reset value:** defaults, `SCAN_MAX`=8; hold reset -> `Data_out`=16'hFF00 and `Data_vld`=0. Release -> first pulse at edge 8 with `Data_out`=16'hC001 (digit 0 showing "0", 3F inverted).
- **Full frame:** `Disp_Data`=32'h89ABCDEF, `Dot`=0, `Blank`=0 -> 8 pulses spaced 8 clocks apart. Words in order: 16'h8E01 (F), 16'h8602 (E), 16'hA104 (d), 16'hC608 (C), 16'h8310 (b), 16'h8820 (A), 16'h9040 (9), 16'h8080 (8). Then digit 0 repeats.
- **Dot and blank:** `Dot`=8'h01, `Blank`=8'h02, `Disp_Data`=32'h00000012 -> digit 0 word is 16'h2401 (5B with DP set, inverted). Digit 1 word is 16'hFF02.
- **Tear-free capture:** change `Disp_Data` from 32'h0 to 32'hFFFFFFFF after the digit-3 pulse -> digits 4..7 still show "0" (C0). The next frame shows "F" on all digits (16'h8Exx).
- **Reset mid-frame:** assert `Reset_n` low 3 clocks after the digit-5 pulse -> outputs return to 16'hFF00/0 asynchronously. After release, the next pulse comes 8 clocks later and is digit 0.
- **Parameter polarity:** `SEG_ACTIVE_LOW`=0, `SEL_ACTIVE_LOW`=1, `Disp_Data`=32'h7 -> digit 0 word is 16'h07FE. Reset word is 16'h00FF.
